// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the two-digit BCD score counter.
// Digit width, BCD limit, step width and FSM state encoding.
package scoreboard_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned STEP_W = 2;

  typedef enum logic {
    StIdle = 1'b0,
    StStep = 1'b1
  } state_e;

  // A step request of 0 counts as a single point.
  function automatic logic [STEP_W-1:0] step_units(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with 9<->0 wrap; carry/borrow flag a wrap on this clock.
// digit_next exposes the value the register takes on the next rising edge.
module bcd_digit
  import scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  output logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] digit_next,
  output logic             carry,
  output logic             borrow
);

  always_comb begin
    carry      = en & dir & (digit == BCD_MAX);
    borrow     = en & ~dir & (digit == '0);
    digit_next = digit;
    if (clr) begin
      digit_next = '0;
    end else if (en) begin
      if (dir) begin
        digit_next = carry ? '0 : digit + BCD_W'(1);
      end else begin
        digit_next = borrow ? BCD_MAX : digit - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else begin
      digit <= digit_next;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit saturating BCD score register driven by synchronised, edge-detected buttons.
// Each accepted request applies 1..3 units, one per clock, while busy is high.
module score_bcd_counter
  import scoreboard_pkg::*;
#(
  parameter int unsigned MAX_SCORE   = 99,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic              clr,
  input  logic [STEP_W-1:0] step,
  output logic [BCD_W-1:0]  bcd_tens,
  output logic [BCD_W-1:0]  bcd_ones,
  output logic              busy,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [BCD_W-1:0] MaxTens = BCD_W'(MAX_SCORE / 10);
  localparam logic [BCD_W-1:0] MaxOnes = BCD_W'(MAX_SCORE % 10);

  logic [SYNC_STAGES-1:0] inc_sync_q, dec_sync_q;
  logic                   inc_prev_q, dec_prev_q;
  logic                   inc_edge_q, dec_edge_q;

  // Edge flops are registered so the request lands on the clock after the sync output rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_sync_q <= '0;
      dec_sync_q <= '0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      inc_edge_q <= 1'b0;
      dec_edge_q <= 1'b0;
    end else begin
      inc_sync_q <= {inc_sync_q[SYNC_STAGES-2:0], inc_btn};
      dec_sync_q <= {dec_sync_q[SYNC_STAGES-2:0], dec_btn};
      inc_prev_q <= inc_sync_q[SYNC_STAGES-1];
      dec_prev_q <= dec_sync_q[SYNC_STAGES-1];
      inc_edge_q <= inc_sync_q[SYNC_STAGES-1] & ~inc_prev_q;
      dec_edge_q <= dec_sync_q[SYNC_STAGES-1] & ~dec_prev_q;
    end
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              unit_en;
  logic              at_max_q, at_min_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inc_edge_q ^ dec_edge_q) begin
            state_d = StStep;
            dir_d   = inc_edge_q;
            rem_d   = step_units(step);
          end
        end
        StStep: begin
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A saturated unit still consumes a cycle but leaves the digits alone.
  always_comb begin
    unit_en = (state_q == StStep) && !clr && (dir_q ? !at_max_q : !at_min_q);
    busy    = (state_q == StStep);
    at_max  = at_max_q;
    at_min  = at_min_q;
  end

  logic [BCD_W-1:0] ones_next, tens_next;
  logic             ones_carry, ones_borrow;
  logic             tens_carry_unused, tens_borrow_unused;

  bcd_digit u_ones (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (unit_en),
    .dir        (dir_q),
    .digit      (bcd_ones),
    .digit_next (ones_next),
    .carry      (ones_carry),
    .borrow     (ones_borrow)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (ones_carry | ones_borrow),
    .dir        (dir_q),
    .digit      (bcd_tens),
    .digit_next (tens_next),
    .carry      (tens_carry_unused),
    .borrow     (tens_borrow_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      at_max_q <= (tens_next == MaxTens) && (ones_next == MaxOnes);
      at_min_q <= (tens_next == '0) && (ones_next == '0);
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Randomised and directed bench for score_bcd_counter against a cycle-level behavioural model.
module tb_score_bcd_counter;

  localparam int MAX  = 99;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] step = 2'd0;
  logic [3:0] bcd_tens, bcd_ones;
  logic       busy, at_max, at_min;

  score_bcd_counter #(
    .MAX_SCORE   (MAX),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inc_btn  (inc_btn),
    .dec_btn  (dec_btn),
    .clr      (clr),
    .step     (step),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .busy     (busy),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: integer score, pending-unit counter, button sample history.
  int  m_score = 0;
  bit  m_busy = 0;
  bit  m_dir = 0;
  int  m_rem = 0;
  bit  m_valid = 0;
  bit  m_isamp[SYNC];
  bit  m_dsamp[SYNC];
  bit  m_iprev = 0, m_dprev = 0, m_iedge = 0, m_dedge = 0;

  always @(posedge clk) begin
    bit ei, ed;
    if (reset) begin
      m_score = 0; m_busy = 0; m_rem = 0; m_dir = 0;
      for (int k = 0; k < SYNC; k++) begin m_isamp[k] = 0; m_dsamp[k] = 0; end
      m_iprev = 0; m_dprev = 0; m_iedge = 0; m_dedge = 0;
      m_valid = 1;
    end else begin
      ei = m_isamp[SYNC-1] && !m_iprev;
      ed = m_dsamp[SYNC-1] && !m_dprev;
      m_iprev = m_isamp[SYNC-1];
      m_dprev = m_dsamp[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) begin
        m_isamp[k] = m_isamp[k-1];
        m_dsamp[k] = m_dsamp[k-1];
      end
      m_isamp[0] = inc_btn;
      m_dsamp[0] = dec_btn;
      if (clr) begin
        m_score = 0; m_busy = 0;
      end else if (m_busy) begin
        if (m_dir && m_score < MAX) m_score++;
        else if (!m_dir && m_score > 0) m_score--;
        if (m_rem == 1) m_busy = 0;
        else m_rem--;
      end else if (m_iedge != m_dedge) begin
        m_busy = 1; m_dir = m_iedge;
        m_rem = (step == 0) ? 1 : int'(step);
      end
      m_iedge = ei;
      m_dedge = ed;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_tens", bcd_tens, m_score / 10);
      check("model_ones", bcd_ones, m_score % 10);
      check("model_busy", busy, int'(m_busy));
      check("model_at_max", at_max, int'(m_score == MAX));
      check("model_at_min", at_min, int'(m_score == 0));
      check("tens_range", bcd_tens <= 4'd9, 1);
      check("ones_range", bcd_ones <= 4'd9, 1);
    end
  end

  int rec_score[11];
  bit rec_busy[11];

  function automatic int score_now();
    return int'(bcd_tens) * 10 + int'(bcd_ones);
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int k = 1; k <= 10; k++) c += int'(rec_busy[k]);
    return c;
  endfunction

  // Button sampled high at clock N; rec_*[k] hold outputs after clock N+k.
  task automatic press(input logic i, input logic d, input logic [1:0] st,
                       input int re_at, input int clr_at);
    @(negedge clk); inc_btn = i; dec_btn = d; step = st;
    @(negedge clk); inc_btn = 1'b0; dec_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rec_score[k] = score_now();
      rec_busy[k]  = busy;
      if (re_at != 0 && k == re_at - 1) inc_btn = 1'b1;
      if (k == re_at) inc_btn = 1'b0;
      if (clr_at != 0 && k == clr_at - 1) clr = 1'b1;
      if (k == clr_at) clr = 1'b0;
    end
  endtask

  task automatic set_score(input int v);
    int r = v;
    inc_btn = 1'b0; dec_btn = 1'b0; reset = 1'b0; clr = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    while (r >= 3) begin press(1'b1, 1'b0, 2'd3, 0, 0); r -= 3; end
    if (r > 0) press(1'b1, 1'b0, 2'(r), 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_tens", bcd_tens, 0);
    check("reset_ones", bcd_ones, 0);
    check("reset_busy", busy, 0);
    check("reset_at_min", at_min, 1);
    check("reset_at_max", at_max, 0);

    // 08 + 3
    set_score(8);
    press(1'b1, 1'b0, 2'd3, 0, 0);
    check("inc3_n3", rec_score[3], 8);
    check("inc3_n4", rec_score[4], 9);
    check("inc3_n5", rec_score[5], 10);
    check("inc3_n6", rec_score[6], 11);
    check("inc3_busy_cycles", busy_count(), 3);

    // saturation at top
    set_score(98);
    press(1'b1, 1'b0, 2'd3, 0, 0);
    check("sat_hi_n4", rec_score[4], 99);
    check("sat_hi_n5", rec_score[5], 99);
    check("sat_hi_n6", rec_score[6], 99);
    check("sat_hi_at_max", at_max, 1);
    check("sat_hi_busy_cycles", busy_count(), 3);
    press(1'b0, 1'b1, 2'd1, 0, 0);
    check("sat_hi_dec1", rec_score[10], 98);

    // saturation at bottom, step 0
    set_score(1);
    press(1'b0, 1'b1, 2'd2, 0, 0);
    check("sat_lo_n4", rec_score[4], 0);
    check("sat_lo_n5", rec_score[5], 0);
    check("sat_lo_at_min", at_min, 1);
    check("sat_lo_busy_cycles", busy_count(), 2);
    press(1'b0, 1'b1, 2'd0, 0, 0);
    check("step0_score", rec_score[10], 0);
    check("step0_busy_cycles", busy_count(), 1);

    // simultaneous edges, then a request while busy
    set_score(5);
    press(1'b1, 1'b1, 2'd3, 0, 0);
    check("both_score", rec_score[10], 5);
    check("both_busy_cycles", busy_count(), 0);
    press(1'b1, 1'b0, 2'd3, 2, 0);
    check("while_busy_score", rec_score[10], 8);
    check("while_busy_cycles", busy_count(), 3);

    // clr during second unit
    set_score(40);
    press(1'b1, 1'b0, 2'd3, 0, 5);
    check("clr_n3", rec_score[3], 40);
    check("clr_n4", rec_score[4], 41);
    check("clr_n5", rec_score[5], 0);
    check("clr_n5_busy", rec_busy[5], 0);
    check("clr_n10", rec_score[10], 0);
    check("clr_busy_cycles", busy_count(), 2);

    // reset held 3 clocks mid-step
    set_score(20);
    @(negedge clk); inc_btn = 1'b1; step = 2'd3;
    @(negedge clk); inc_btn = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midreset_score", score_now(), 0);
    check("midreset_busy", busy, 0);
    check("midreset_at_min", at_min, 1);
    repeat (8) @(negedge clk);
    check("midreset_after", score_now(), 0);

    // random preset levels
    for (int t = 0; t < 4; t++) begin
      int v = $urandom_range(0, MAX);
      set_score(v);
      check("preset_level", score_now(), v);
    end

    // random button activity
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) inc_btn = ~inc_btn;
      if ($urandom_range(0, 4) == 0) dec_btn = ~dec_btn;
      step  = 2'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; clr = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
